// File: rtl/work_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : work_serial_tx
// Purpose  : Serialises a 512-bit SHA-256 work unit {data2, midstate} as
//            64 UART 8N1 bytes, LSB byte first, LSB bit first.
// Revision : 1.0 - initial release
// ============================================================================
module work_serial_tx #(
    parameter int CLK_HZ = 80000000,
    parameter int BAUD   = 115200
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         txd,
    output logic         busy,
    output logic         done
);

    localparam int c_DIV = CLK_HZ / BAUD;
    localparam int c_BW  = (c_DIV >= 2) ? $clog2(c_DIV) : 1;
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(c_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    localparam logic [5:0] c_LAST_BYTE = 6'd63;
    localparam logic [2:0] c_LAST_BIT  = 3'd7;

    generate
        if (c_DIV < 2) begin : g_div_check
            $error("work_serial_tx: CLK_HZ / BAUD must be at least 2");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [c_BW-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [5:0]      r_byte;
    logic [511:0]    r_shift;
    logic            r_txd;
    logic            r_busy;
    logic            r_done;

    logic [1:0]      w_state_nxt;
    logic [c_BW-1:0] w_baud_nxt;
    logic [2:0]      w_bit_nxt;
    logic [5:0]      w_byte_nxt;
    logic [511:0]    w_shift_nxt;
    logic            w_frame_end;
    logic            w_baud_last;
    logic [7:0]      w_cur_byte;
    logic            w_txd_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    assign w_baud_last = (r_baud == c_BAUD_LAST);

    // State register: outputs are registered from the next-state values so
    // txd/busy change on the same edge that accepts load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_shift_nxt = r_shift;
        w_frame_end = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (load) begin
                    w_state_nxt = c_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_byte_nxt  = '0;
                    w_shift_nxt = {data2, midstate};
                end
            end
            c_START: begin
                if (w_baud_last) begin
                    w_state_nxt = c_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            c_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_bit == c_LAST_BIT) begin
                        w_state_nxt = c_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            c_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_byte == c_LAST_BYTE) begin
                        w_state_nxt = c_IDLE;
                        w_frame_end = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no gap.
                        w_state_nxt = c_START;
                        w_byte_nxt  = r_byte + 6'd1;
                        w_shift_nxt = {8'h00, r_shift[511:8]};
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign w_cur_byte = w_shift_nxt[7:0];

    always_comb begin
        w_txd_nxt  = 1'b1;
        w_busy_nxt = (w_state_nxt != c_IDLE);
        w_done_nxt = w_frame_end;
        case (w_state_nxt)
            c_START: w_txd_nxt = 1'b0;
            c_DATA:  w_txd_nxt = w_cur_byte[w_bit_nxt];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    assign txd  = r_txd;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: doc/work_serial_tx.md
# work_serial_tx

Serialises one SHA-256 work unit into a 64-byte UART 8N1 frame. The work unit is a 256-bit midstate plus 256-bit data2. It is the transmit end of the miner's work-reception link.

The block runs in the `hash_clk` domain. It drives a work line to a downstream miner, either another board or an external miner chained on the expansion connector. The frame layout matches the miner's serial work receiver byte-for-byte, so a second board can be fed from this one.

## Interface
Parameters:
- `CLK_HZ`, default 80000000: frequency of `clk` in Hz.
- `BAUD`, default 115200: line rate in bits per second.
- Derived: `DIV = CLK_HZ / BAUD`, integer-truncated. The default gives 694 clocks per bit. `DIV >= 2` is required, and elaboration fails otherwise.

Ports:
- `clk`  in  1: hash clock. All logic is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: start-request strobe. Accepted only in a cycle where `busy=0`.
- `midstate`  in  256: work midstate. Captured on an accepted `load`.
- `data2`  in  256: work data2 tail. Captured on an accepted `load`.
- `txd`  out  1: UART line, idle high. Registered.
- `busy`  out  1: high from the cycle after an accepted `load` until the last stop bit completes.
- `done`  out  1: one-cycle pulse marking frame completion.

## Operation
- Capture:
  - On an accepted `load`, `{data2, midstate}` is copied into a 512-bit shift register.
  - Inputs may change freely after the capture cycle.
- Byte order:
  - Byte 0 is `midstate[7:0]`, byte 31 is `midstate[255:248]`.
  - Byte 32 is `data2[7:0]`, byte 63 is `data2[255:248]`.
  - After each byte the shift register moves right by 8 bits.
- Bit order within each byte: start bit (0), then d0 through d7 (LSB first), then stop bit (1).
- FSM states:
  - IDLE: `txd=1`, `busy=0`. An accepted `load` goes to START and clears the byte counter.
  - START: `txd=0` for DIV clocks, then go to DATA with the bit index cleared.
  - DATA: `txd` = current data bit for DIV clocks per bit. After bit 7, go to STOP.
  - STOP: `txd=1` for DIV clocks. Then:
    - if the byte counter is not 63: increment it, shift the register, go to START;
    - if the byte counter is 63: go to IDLE and pulse `done`.
- Counters and widths:
  - Baud counter: `$clog2(DIV)` bits, counts 0..DIV-1.
  - Bit index: 3 bits.
  - Byte counter: 6 bits, 0..63. It never wraps inside a frame; the terminal value 63 is decoded explicitly.
- `load` while `busy=1` is ignored. There is no queueing and no error flag.
- There is no inter-byte gap. The stop bit of byte n is followed directly by the start bit of byte n+1.

## Timing
- Reset values (asynchronous, take effect immediately on `reset_n=0`):
  - `txd=1`, `busy=0`, `done=0`.
  - FSM=IDLE, all counters=0.
  - Shift register = 0.
- Start latency: `load` accepted at edge k gives `txd=0` and `busy=1` from edge k+1.
- Bit time: exactly DIV clocks.
- Frame duration: exactly 640·DIV clocks from `txd` falling for byte 0 to the end of the last stop bit.
- End of frame: on the edge that ends the last stop bit, `busy` falls and `done=1` for that single cycle.
- Back-to-back frames:
  - A `load` in the same cycle as `done` is accepted, since `busy=0` in that cycle.
  - The next start bit then begins one clock later, with at most one idle-high clock between frames.
- Reset mid-frame:
  - `txd` returns high at once and the frame is abandoned; no `done` is produced.
  - The downstream receiver sees a truncated byte. Resynchronising it is the system's responsibility.

## Test plan
- Reset values:
  - Stimulus: assert `reset_n=0` with `load=1` held.
  - Required: `txd=1`, `busy=0`, `done=0` throughout; no frame starts until after release.
- Full frame (bench uses `CLK_HZ=16`, `BAUD=1`, so DIV=16):
  - Stimulus: midstate bytes 0x00..0x1F and data2 bytes 0x20..0x3F, i.e. `midstate[7:0]=0x00`, `data2[255:248]=0x3F`.
  - Required: a bench UART decoder recovers bytes 0x00..0x3F in order.
  - Required: every bit is exactly 16 clocks and `busy` stays high for 10240 clocks.
- Capture isolation:
  - Stimulus: change `midstate` and `data2` to all-ones the cycle after `load`.
  - Required: the decoded frame is still 0x00..0x3F.
- Ignored load:
  - Stimulus: pulse `load` at byte 10 with different data.
  - Required: the frame is unchanged and `done` fires exactly once, at 10240 clocks.
- Back-to-back:
  - Stimulus: assert `load` in the `done` cycle with data bytes all 0xA5.
  - Required: the second frame's start bit begins one clock after `done`.
  - Required: 64 bytes of 0xA5 decode, followed by a second `done`.
- Reset mid-frame:
  - Stimulus: drop `reset_n` at byte 5, bit 3, then issue a new `load`.
  - Required: `txd=1` immediately, no `done`, and the new frame is decoded correctly from byte 0.
